// File: rtl/apbdma_apb_writer.sv
// apbdma_apb_writer: turns the downsizer's narrow beat stream into APB4
// writes at an incrementing address, one command (address, beat count) at a
// time, and reports completion and slave-error status.
module apbdma_apb_writer #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // command
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [LenWidth-1:0]    cmd_len_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  // beat stream from the downsizer
  input  logic [DataWidth-1:0]   data_i,
  input  logic [DataWidth/8-1:0] strb_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  // APB4 manager
  output logic [AddrWidth-1:0]   paddr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  output logic [2:0]             pprot_o,
  input  logic                   pready_i,
  input  logic                   pslverr_i,
  // status
  output logic                   done_o,
  output logic                   error_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [LenWidth-1:0]    len_q;
  logic [LenWidth-1:0]    cnt_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   wstrb_q;
  logic                   psel_q, penable_q;
  logic                   done_q, error_q;
  logic                   last_beat;

  // The counter equals the latched length on the final beat; an all-ones
  // length therefore runs 2^LenWidth beats without the counter overflowing.
  assign last_beat = (cnt_q == len_q);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      state_q <= state_d;
    end
  end

  // Next-state logic and the two handshake readies.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    ready_o     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ready_o = 1'b1;
        if (valid_i) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          if (last_beat)      state_d = ST_IDLE;
          else if (pslverr_i) state_d = ST_DRAIN;
          else                state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        // Swallow the rest of the beats so the downsizer never stalls.
        ready_o = 1'b1;
        if (valid_i && last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: address, length, beat counter, write data and status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            addr_q  <= cmd_addr_i;
            len_q   <= cmd_len_i;
            cnt_q   <= '0;
            error_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (valid_i) begin
            wdata_q <= data_i;
            wstrb_q <= strb_i;
          end
        end
        ST_ACCESS: begin
          if (pready_i) begin
            if (pslverr_i) error_q <= 1'b1;
            if (last_beat) begin
              done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + LenWidth'(1);
              // Address wraps modulo 2^AddrWidth; no advance once draining.
              if (!pslverr_i) addr_q <= addr_q + AddrWidth'(StrbWidth);
            end
          end
        end
        ST_DRAIN: begin
          if (valid_i) begin
            if (last_beat) done_q <= 1'b1;
            else           cnt_q  <= cnt_q + LenWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // APB phase flags registered from the next state so psel/penable are
  // glitch-free and drop asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      psel_q    <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_q <= (state_d == ST_ACCESS);
    end
  end

  assign paddr_o   = addr_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = 1'b1;
  assign pwdata_o  = wdata_q;
  assign pstrb_o   = wstrb_q;
  assign pprot_o   = 3'b000;
  assign done_o    = done_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_apbdma_apb_writer.sv
// Directed bench for apbdma_apb_writer: a beat driver, an APB slave with
// programmable wait states / error injection, and a write log checked
// against hand-computed addresses and data.
module tb_apbdma_apb_writer;

  logic        clk_i, rst_ni;
  logic [31:0] cmd_addr_i;
  logic [15:0] cmd_len_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [31:0] data_i;
  logic [3:0]  strb_i;
  logic        valid_i, ready_o;
  logic [31:0] paddr_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic        pready_i, pslverr_i;
  logic        done_o, error_o;

  apbdma_apb_writer dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cmd_addr_i (cmd_addr_i),
    .cmd_len_i  (cmd_len_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .data_i     (data_i),
    .strb_i     (strb_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .paddr_o    (paddr_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pstrb_o    (pstrb_o),
    .pprot_o    (pprot_o),
    .pready_i   (pready_i),
    .pslverr_i  (pslverr_i),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t         wq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wait_cfg = 0;
  int          slverr_beat = -1;
  int          apb_idx = 0;
  int          done_cnt = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // APB slave + monitor: wait states, error injection, write log, and
  // stability of address/data/strobe from Setup through the end of Access.
  initial begin : apb_slave
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_strb;
    int          wcnt;
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    wcnt      = 0;
    s_addr    = '0;
    s_data    = '0;
    s_strb    = '0;
    forever begin
      tick();
      if (done_o) done_cnt++;
      if (psel_o) check("ready_during_apb", ready_o, 1'b0);
      if (psel_o && !penable_o) begin
        s_addr    = paddr_o;
        s_data    = pwdata_o;
        s_strb    = pstrb_o;
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        wcnt      = 0;
      end else if (psel_o && penable_o) begin
        check("stable_paddr", paddr_o, s_addr);
        check("stable_pwdata", pwdata_o, s_data);
        check("stable_pstrb", pstrb_o, s_strb);
        if (!pready_i) begin
          if (wcnt >= wait_cfg) begin
            pready_i  = 1'b1;
            pslverr_i = (apb_idx == slverr_beat);
            wq.push_back('{addr: paddr_o, data: pwdata_o, strb: pstrb_o});
            apb_idx++;
          end else begin
            wcnt++;
          end
        end
      end else begin
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        wcnt      = 0;
      end
    end
  end

  task automatic issue_cmd(input logic [31:0] a, input logic [15:0] l);
    int n = 0;
    apb_idx     = 0;
    cmd_addr_i  = a;
    cmd_len_i   = l;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 100) begin tick(); n++; end
    check("cmd_accept", n < 100, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
    check("wait_after_cmd", ready_o, 1'b1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    data_i  = d;
    strb_i  = s;
    valid_i = 1'b1;
    while (!ready_o && n < 100) begin tick(); n++; end
    check("beat_accept", n < 100, 1'b1);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err);
    int n = 0;
    while (!done_o && n < 200) begin tick(); n++; end
    check("done_seen", done_o, 1'b1);
    check("done_error", error_o, exp_err);
    check("done_cmd_ready", cmd_ready_o, 1'b1);
    tick();
    check("done_one_cycle", done_o, 1'b0);
  endtask

  task automatic check_wr(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    if (i < wq.size()) begin
      check("wr_addr", wq[i].addr, a);
      check("wr_data", wq[i].data, d);
      check("wr_strb", wq[i].strb, s);
    end else begin
      check("wr_missing", i, wq.size() + 1000);
    end
  endtask

  initial begin : main
    logic [3:0] strb_tab[4];
    int         dc;
    strb_tab    = '{4'hF, 4'h3, 4'hC, 4'h1};
    rst_ni      = 1'b0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    cmd_valid_i = 1'b0;
    data_i      = '0;
    strb_i      = '0;
    valid_i     = 1'b0;

    // Reset values
    #2;
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_ready", ready_o, 1'b0);
    check("rst_psel", psel_o, 1'b0);
    check("rst_penable", penable_o, 1'b0);
    check("rst_paddr", paddr_o, 32'h0);
    check("rst_pwdata", pwdata_o, 32'h0);
    check("rst_pstrb", pstrb_o, 4'h0);
    check("rst_done", done_o, 1'b0);
    check("rst_error", error_o, 1'b0);
    check("rst_pwrite", pwrite_o, 1'b1);
    check("rst_pprot", pprot_o, 3'b000);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // Single beat write
    wq.delete();
    issue_cmd(32'h1000, 16'd0);
    check("t1_cmd_ready_wait", cmd_ready_o, 1'b0);
    send_beat(32'hDEADBEEF, 4'hF);
    check("t1_setup_psel", psel_o, 1'b1);
    check("t1_setup_penable", penable_o, 1'b0);
    check("t1_setup_paddr", paddr_o, 32'h1000);
    check("t1_setup_pwdata", pwdata_o, 32'hDEADBEEF);
    tick();
    check("t1_access_penable", penable_o, 1'b1);
    tick();
    check("t1_done_cycle", done_o, 1'b1);
    wait_done(1'b0);
    check("t1_count", wq.size(), 1);
    check_wr(0, 32'h1000, 32'hDEADBEEF, 4'hF);

    // Multi-beat with two wait states per beat
    wq.delete();
    wait_cfg = 2;
    issue_cmd(32'h2000, 16'd3);
    for (int i = 0; i < 4; i++) send_beat(32'hA0000000 + i, strb_tab[i]);
    wait_done(1'b0);
    wait_cfg = 0;
    check("t2_count", wq.size(), 4);
    for (int i = 0; i < 4; i++) check_wr(i, 32'h2000 + 4 * i, 32'hA0000000 + i, strb_tab[i]);

    // Error on beat 1, beats 2 and 3 drained
    wq.delete();
    slverr_beat = 1;
    issue_cmd(32'h3000, 16'd3);
    send_beat(32'hB0, 4'hF);
    send_beat(32'hB1, 4'hF);
    send_beat(32'hB2, 4'hF);
    check("t3_drain_psel2", psel_o, 1'b0);
    send_beat(32'hB3, 4'hF);
    check("t3_drain_psel3", psel_o, 1'b0);
    wait_done(1'b1);
    slverr_beat = -1;
    check("t3_count", wq.size(), 2);
    check_wr(0, 32'h3000, 32'hB0, 4'hF);
    check_wr(1, 32'h3004, 32'hB1, 4'hF);
    tick(); tick();
    check("t3_error_holds", error_o, 1'b1);

    // Address wrap; accepting the command clears the old error
    wq.delete();
    issue_cmd(32'hFFFFFFFC, 16'd1);
    check("t4_error_cleared", error_o, 1'b0);
    send_beat(32'hC0, 4'hF);
    send_beat(32'hC1, 4'h5);
    wait_done(1'b0);
    check("t4_count", wq.size(), 2);
    check_wr(0, 32'hFFFFFFFC, 32'hC0, 4'hF);
    check_wr(1, 32'h00000000, 32'hC1, 4'h5);

    // Upstream bubble, then back-to-back command in the done cycle
    wq.delete();
    issue_cmd(32'h5000, 16'd1);
    send_beat(32'hD0, 4'hF);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("t5_bubble_psel", psel_o, 1'b0);
      check("t5_bubble_ready", ready_o, 1'b1);
      tick();
    end
    send_beat(32'hD1, 4'hF);
    dc = 0;
    while (!done_o && dc < 200) begin tick(); dc++; end
    check("t5_done_seen", done_o, 1'b1);
    check("t5_b2b_cmd_ready", cmd_ready_o, 1'b1);
    apb_idx     = 0;
    cmd_addr_i  = 32'h6000;
    cmd_len_i   = 16'd0;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    check("t5_b2b_wait", ready_o, 1'b1);
    check("t5_b2b_done_low", done_o, 1'b0);
    send_beat(32'hE0, 4'h8);
    wait_done(1'b0);
    check("t5_count", wq.size(), 3);
    check_wr(0, 32'h5000, 32'hD0, 4'hF);
    check_wr(1, 32'h5004, 32'hD1, 4'hF);
    check_wr(2, 32'h6000, 32'hE0, 4'h8);

    // Reset mid-Access
    wq.delete();
    wait_cfg = 3;
    issue_cmd(32'h7000, 16'd1);
    send_beat(32'hF0, 4'hF);
    tick();
    check("t6_in_access", penable_o, 1'b1);
    dc = done_cnt;
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_psel", psel_o, 1'b0);
    check("t6_rst_penable", penable_o, 1'b0);
    check("t6_rst_paddr", paddr_o, 32'h0);
    check("t6_rst_pwdata", pwdata_o, 32'h0);
    check("t6_rst_pstrb", pstrb_o, 4'h0);
    check("t6_rst_cmd_ready", cmd_ready_o, 1'b1);
    check("t6_rst_ready", ready_o, 1'b0);
    check("t6_rst_error", error_o, 1'b0);
    tick(); tick();
    rst_ni = 1'b1;
    wait_cfg = 0;
    tick(); tick(); tick();
    check("t6_no_done", done_cnt, dc);
    wq.delete();
    issue_cmd(32'h8000, 16'd0);
    send_beat(32'h12345678, 4'hA);
    wait_done(1'b0);
    check("t6_count", wq.size(), 1);
    check_wr(0, 32'h8000, 32'h12345678, 4'hA);

    tick();
    check("total_done_pulses", done_cnt, 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apbdma_apb_writer.md
# apbdma_apb_writer

Downstream stage of the APB DMA width downsizer. It consumes the narrow data/strobe beat stream the downsizer produces and turns each beat into one APB4 write transfer at an incrementing address. It runs one command (start address, beat count) at a time and reports completion and error status back to the DMA control logic.

## Interface
- AddrWidth, 32, APB address width
- DataWidth, 32, beat/APB data width (multiple of 8); the downsizer's OutDataWidth
- LenWidth, 16, width of the beat-count field
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low
- cmd_addr_i  in  AddrWidth  start address of the transfer
- cmd_len_i  in  LenWidth  number of beats minus one
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- data_i  in  DataWidth  beat data from the downsizer
- strb_i  in  DataWidth/8  beat byte strobes
- valid_i  in  1  beat valid
- ready_o  out  1  beat accepted when high with valid_i
- paddr_o  out  AddrWidth  APB address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write; tied 1
- pwdata_o  out  DataWidth  APB write data
- pstrb_o  out  DataWidth/8  APB write strobes
- pprot_o  out  3  APB protection; tied 3'b000
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error
- done_o  out  1  one-cycle pulse at end of command
- error_o  out  1  command status: high if any beat got pslverr

## Operation
- FSM states: Idle, Wait, Setup, Access, Drain.
- Idle: cmd_ready_o=1, ready_o=0. On cmd_valid_i, do the following and go to Wait:
  - latch cmd_addr_i into the address register and cmd_len_i into the length register
  - clear the beat counter and error_o.
- Wait: ready_o=1. On valid_i, latch data_i/strb_i into pwdata_o/pstrb_o and go to Setup.
- Setup: psel_o=1, penable_o=0 for exactly one cycle, then go to Access.
- Access: psel_o=1, penable_o=1. paddr_o, pwdata_o and pstrb_o are held stable until pready_i. On pready_i:
  - pslverr_i=1 sets error_o.
  - If this is the last beat (counter==len), pulse done_o and go to Idle.
  - Else, on pslverr_i=1, increment the counter and go to Drain.
  - Else, increment the counter, add DataWidth/8 to the address, and go to Wait.
- Drain: no APB activity, ready_o=1. Each valid_i handshake consumes one beat and increments the counter. The handshake on beat len pulses done_o and returns to Idle. This keeps the downsizer from stalling after an error.
- Address arithmetic is modulo 2^AddrWidth: the address wraps silently at all-ones.
- The beat counter is LenWidth bits. cmd_len_i=all-ones means 2^LenWidth beats.
- error_o stays valid after done_o until the next command is accepted.

## Timing
- Reset values:
  - cmd_ready_o=1 (Idle); ready_o=0
  - psel_o=0, penable_o=0
  - paddr_o=0, pwdata_o=0, pstrb_o=0
  - done_o=0, error_o=0
  - pwrite_o=1, pprot_o=0
- Reset asserted mid-transfer: psel_o and penable_o drop asynchronously. The command is discarded, and no done_o is produced.
- All APB outputs and done_o/error_o come from registers.
- Command accept to first beat acceptable: 1 cycle (Wait entered the cycle after the handshake).
- Per beat, with valid_i present and pready_i=1 immediately: 3 cycles (Wait, Setup, Access). Each pready_i wait cycle adds one cycle.
- done_o is high in the cycle after the final pready_i or final Drain handshake. cmd_ready_o is also 1 in that cycle, so a new command is accepted back-to-back.
- ready_o is never high in Setup or Access. No beat is accepted while an APB transfer is in flight.
- pready_i and pslverr_i are ignored outside Access.
- cmd_valid_i is ignored outside Idle.

## Test plan
- Single beat write:
  - Stimulus: cmd addr=0x1000, len=0, beat data=0xDEADBEEF, strb=0xF, pready_i=1.
  - Required: one APB write to 0x1000 with pwdata=0xDEADBEEF, pstrb=0xF, Setup then Access.
  - Then done_o=1 for one cycle with error_o=0, and cmd_ready_o=1 in that same cycle.
- Multi-beat with wait states:
  - Stimulus: addr=0x2000, len=3, pready_i delayed 2 cycles on every beat.
  - Required: writes to 0x2000, 0x2004, 0x2008, 0x200C in order.
  - APB signals stay stable through every wait cycle, and done_o fires once after the 4th write.
- Error with drain:
  - Stimulus: len=3, pslverr_i=1 on beat 1.
  - Required: only beats 0 and 1 appear on APB; beats 2 and 3 are accepted via ready_o with no psel_o.
  - Then done_o=1 with error_o=1.
- Address wrap:
  - Stimulus: addr=0xFFFFFFFC, len=1.
  - Required: second write goes to 0x00000000.
- Upstream bubbles and back-to-back commands:
  - Stimulus: valid_i low for 5 cycles between beats; a second command presented while done_o is high.
  - Required: psel_o stays low during the bubbles, and the second command is accepted in the done_o cycle.
- Reset mid-Access:
  - Stimulus: rst_ni low while penable_o=1.
  - Required: psel_o and penable_o drop immediately, all outputs take their reset values, and no done_o is produced.
  - After release, a new command completes normally.
